rr_grant_arbiter4: RTL

- Four-requester round-robin arbiter with locked grants.
- Produces a registered 2-bit grant index plus valid. This index is the select input of the downstream 2-to-4 decoder, which turns it into one-hot enables.
- A grant is held until the owner releases it, drops its request, or a hold timeout expires.
- Used wherever four sources share one resource, such as the register-file write port or a bus.

---
 rtl/rr_grant_arbiter4.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rr_grant_arbiter4.sv
// rr_grant_arbiter4
//   Round-robin arbiter for four requesters with locked grants. A winner is
//   chosen only while idle, using a rotating search that starts at the
//   requester after the previous owner. The grant stays locked until the
//   owner strobes done, drops its request, or has held the grant for
//   MAX_HOLD cycles. The grant index is registered and stays stable for the
//   whole grant, so it can drive a downstream 2-to-4 decoder select directly.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles a grant may be held (2..255)
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   req[3:0]    : level-sensitive request lines, bit i = requester i
//   done        : release strobe from the current owner (ignored when idle)
//   grant_valid : registered, high while a grant is active
//   grant_idx   : registered index of the granted requester
//   timeout     : registered one-cycle pulse marking a forced release
module rr_grant_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [1:0] grant_idx,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             owner_req;
  logic             cnt_last;

  // Rotating priority search. Offsets are scanned from farthest to nearest
  // so the nearest set request (starting at ptr) is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign owner_req = req[idx_q];
  assign cnt_last  = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done || !owner_req || cnt_last) begin
          valid_d = 1'b0;
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
          // Only a pure expiry counts as forced; a concurrent done or a
          // dropped request is an ordinary release.
          to_d    = !done && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b00;
      idx_q   <= 2'b00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign timeout     = to_q;

endmodule
